multicycle_control: RTL and testbench

- Multi-cycle main control FSM for the RV32I datapath, successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with instruction and data memory.
- Adds optional multi-cycle M-extension multiply (MUL), illegal-instruction detection and a one-cycle retire strobe (pc_write).

---
 rtl/multicycle_control.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM for the multi-cycle RV32I datapath. Each accepted
//   instruction is sequenced through FETCH / DECODE / EXEC / MEM / WB, with an
//   optional multi-cycle MUL wait, an illegal-instruction trap state, and a
//   single pc_write retire strobe per instruction.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   instr_valid          fetched instruction present on opcode/funct7
//   opcode, funct7       instruction[6:0], instruction[31:25]
//   mem_ready            data memory completes the current access
//   instr_ready          FSM accepts an instruction (FETCH)
//   branch               branch compare / PC-select enable
//   mem_read, mem_write  load / store request, held until mem_ready
//   mem_to_reg           writeback selects memory data
//   alu_op[2:0]          000 R, 001 I, 010 S, 011 B, 100 U, 101 J, 110 load, 111 JALR
//   alu_src              ALU operand B = immediate
//   reg_write            register file write enable
//   mul_start            one-cycle multiplier launch pulse
//   pc_write             one-cycle retire strobe
//   illegal              one-cycle illegal-instruction pulse
//   busy                 FSM not in FETCH
module multicycle_control #(
  parameter int MUL_EN      = 1,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = $clog2(MUL_LATENCY + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  output logic       instr_ready,
  output logic       branch,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic       reg_write,
  output logic       mul_start,
  output logic       pc_write,
  output logic       illegal,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MUL_WAIT, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_ARITH, C_MUL, C_ARI_IMM, C_BRANCH, C_LOAD, C_STORE,
    C_AUIPC, C_LUI, C_JAL, C_JALR, C_ILLEGAL
  } class_t;

  state_t            state, state_nxt;
  class_t            cls, dec_cls;
  logic [CNT_W-1:0]  cnt;
  logic [6:0]        op_q, f7_q;

  function automatic class_t decode_class(input logic [6:0] op, input logic [6:0] f7);
    class_t c;
    case (op)
      7'b0110011: begin
        if (f7 == 7'b0000000 || f7 == 7'b0100000) c = C_ARITH;
        else if (f7 == 7'b0000001 && MUL_EN != 0)  c = C_MUL;
        else                                       c = C_ILLEGAL;
      end
      7'b0010011: c = C_ARI_IMM;
      7'b1100011: c = C_BRANCH;
      7'b0000011: c = C_LOAD;
      7'b0100011: c = C_STORE;
      7'b0010111: c = C_AUIPC;
      7'b0110111: c = C_LUI;
      7'b1101111: c = C_JAL;
      7'b1100111: c = C_JALR;
      default:    c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] alu_op_of(input class_t c);
    logic [2:0] a;
    case (c)
      C_ARI_IMM:         a = 3'b001;
      C_STORE:           a = 3'b010;
      C_BRANCH:          a = 3'b011;
      C_LUI, C_AUIPC:    a = 3'b100;
      C_JAL:             a = 3'b101;
      C_LOAD:            a = 3'b110;
      C_JALR:            a = 3'b111;
      default:           a = 3'b000;
    endcase
    return a;
  endfunction

  function automatic logic alu_src_of(input class_t c);
    return !(c == C_ARITH || c == C_MUL || c == C_BRANCH);
  endfunction

  // Instruction fields are captured only on the accept handshake; the
  // fetch bus is free to change once DECODE is entered.
  always_ff @(posedge clk) begin
    if (instr_valid && instr_ready) begin
      op_q <= opcode;
      f7_q <= funct7;
    end
  end

  assign dec_cls = decode_class(op_q, f7_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      cls   <= C_NONE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) cls <= dec_cls;
      // Counter is loaded at launch so that the count reaching 1 in
      // MUL_WAIT lands WB exactly MUL_LATENCY cycles after mul_start.
      if (state == S_EXEC && cls == C_MUL) cnt <= CNT_W'(MUL_LATENCY - 1);
      else if (state == S_MUL_WAIT)        cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    branch      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_op      = 3'b000;
    alu_src     = 1'b0;
    reg_write   = 1'b0;
    mul_start   = 1'b0;
    pc_write    = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        state_nxt = (dec_cls == C_ILLEGAL) ? S_TRAP : S_EXEC;
      end
      S_TRAP: begin
        illegal   = 1'b1;
        pc_write  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_EXEC: begin
        alu_op  = alu_op_of(cls);
        alu_src = alu_src_of(cls);
        case (cls)
          C_BRANCH: begin
            branch    = 1'b1;
            pc_write  = 1'b1;
            state_nxt = S_FETCH;
          end
          C_MUL: begin
            mul_start = 1'b1;
            state_nxt = (MUL_LATENCY > 1) ? S_MUL_WAIT : S_WB;
          end
          C_LOAD, C_STORE: state_nxt = S_MEM;
          default:         state_nxt = S_WB;
        endcase
      end
      S_MUL_WAIT: begin
        if (cnt == CNT_W'(1)) state_nxt = S_WB;
      end
      S_MEM: begin
        alu_op    = alu_op_of(cls);
        alu_src   = alu_src_of(cls);
        mem_read  = (cls == C_LOAD);
        mem_write = (cls == C_STORE);
        if (mem_ready) begin
          if (cls == C_LOAD) begin
            state_nxt = S_WB;
          end else begin
            // Stores retire directly from MEM; there is no writeback.
            pc_write  = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == C_LOAD);
        pc_write   = 1'b1;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  assign busy = (state != S_FETCH);

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Directed bench for multicycle_control. Three instances share the input
//   bus: default (MUL_EN=1, MUL_LATENCY=4), MUL_LATENCY=1, and MUL_EN=0.
//   All outputs of an instance are packed into one 14-bit vector:
//   [13] instr_ready [12] branch [11] mem_read [10] mem_write [9] mem_to_reg
//   [8:6] alu_op [5] alu_src [4] reg_write [3] mul_start [2] pc_write
//   [1] illegal [0] busy
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [6:0] funct7 = 7'd0;
  logic       mem_ready = 1'b0;

  wire [13:0] va, vb, vc;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MUL_EN(1), .MUL_LATENCY(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .funct7(funct7), .mem_ready(mem_ready),
    .instr_ready(va[13]), .branch(va[12]), .mem_read(va[11]), .mem_write(va[10]),
    .mem_to_reg(va[9]), .alu_op(va[8:6]), .alu_src(va[5]), .reg_write(va[4]),
    .mul_start(va[3]), .pc_write(va[2]), .illegal(va[1]), .busy(va[0])
  );

  multicycle_control #(.MUL_EN(1), .MUL_LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .funct7(funct7), .mem_ready(mem_ready),
    .instr_ready(vb[13]), .branch(vb[12]), .mem_read(vb[11]), .mem_write(vb[10]),
    .mem_to_reg(vb[9]), .alu_op(vb[8:6]), .alu_src(vb[5]), .reg_write(vb[4]),
    .mul_start(vb[3]), .pc_write(vb[2]), .illegal(vb[1]), .busy(vb[0])
  );

  multicycle_control #(.MUL_EN(0), .MUL_LATENCY(4)) u_nomul (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .funct7(funct7), .mem_ready(mem_ready),
    .instr_ready(vc[13]), .branch(vc[12]), .mem_read(vc[11]), .mem_write(vc[10]),
    .mem_to_reg(vc[9]), .alu_op(vc[8:6]), .alu_src(vc[5]), .reg_write(vc[4]),
    .mul_start(vc[3]), .pc_write(vc[2]), .illegal(vc[1]), .busy(vc[0])
  );

  function automatic logic [13:0] mk(input logic ir, input logic br, input logic mr,
                                     input logic mw, input logic m2r, input logic [2:0] aop,
                                     input logic asrc, input logic rw, input logic ms,
                                     input logic pcw, input logic ill, input logic bsy);
    return {ir, br, mr, mw, m2r, aop, asrc, rw, ms, pcw, ill, bsy};
  endfunction

  logic [13:0] v_idle, v_busy, v_wb, v_trap;

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in FETCH (cycle 0), advance to DECODE (cycle 1)
  // and scramble the fetch bus so only the captured fields can matter.
  task automatic accept(input string tag, input logic [6:0] op, input logic [6:0] f7);
    opcode      = op;
    funct7      = f7;
    instr_valid = 1'b1;
    chk({tag, "/fetch"}, va, v_idle);
    step();
    instr_valid = 1'b0;
    opcode      = 7'b1111111;
    funct7      = 7'b1111111;
    chk({tag, "/decode"}, va, v_busy);
    step();
  endtask

  initial begin
    v_idle = mk(1,0,0,0,0,3'b000,0,0,0,0,0,0);
    v_busy = mk(0,0,0,0,0,3'b000,0,0,0,0,0,1);
    v_wb   = mk(0,0,0,0,0,3'b000,0,1,0,1,0,1);
    v_trap = mk(0,0,0,0,0,3'b000,0,0,0,1,1,1);

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset/a", va, v_idle);
    chk("reset/b", vb, v_idle);
    chk("reset/c", vc, v_idle);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle", va, v_idle);

    // ADD: EXEC cycle 2, WB cycle 3, FETCH cycle 4
    accept("add", 7'b0110011, 7'b0000000);
    chk("add/exec", va, mk(0,0,0,0,0,3'b000,0,0,0,0,0,1));
    step();
    chk("add/wb", va, v_wb);
    step();
    chk("add/done", va, v_idle);
    step();
    chk("add/stay", va, v_idle);

    // SUB shares the R-type path
    accept("sub", 7'b0110011, 7'b0100000);
    chk("sub/exec", va, mk(0,0,0,0,0,3'b000,0,0,0,0,0,1));
    step();
    chk("sub/wb", va, v_wb);
    step();

    // LW, mem_ready pulsed in EXEC (ignored), then low for 3 MEM cycles
    accept("lw", 7'b0000011, 7'b0000000);
    mem_ready = 1'b1;
    chk("lw/exec", va, mk(0,0,0,0,0,3'b110,1,0,0,0,0,1));
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lw/mem_stall", va, mk(0,0,1,0,0,3'b110,1,0,0,0,0,1));
      step();
    end
    mem_ready = 1'b1;
    chk("lw/mem_done", va, mk(0,0,1,0,0,3'b110,1,0,0,0,0,1));
    step();
    mem_ready = 1'b0;
    chk("lw/wb", va, mk(0,0,0,0,1,3'b000,0,1,0,1,0,1));
    step();
    chk("lw/done", va, v_idle);

    // SW with mem_ready already high: retires from MEM
    accept("sw", 7'b0100011, 7'b0000000);
    chk("sw/exec", va, mk(0,0,0,0,0,3'b010,1,0,0,0,0,1));
    mem_ready = 1'b1;
    step();
    chk("sw/mem", va, mk(0,0,0,1,0,3'b010,1,0,0,1,0,1));
    step();
    mem_ready = 1'b0;
    chk("sw/done", va, v_idle);

    // MUL across the three configurations
    accept("mul", 7'b0110011, 7'b0000001);
    chk("mul/exec_a", va, mk(0,0,0,0,0,3'b000,0,0,1,0,0,1));
    chk("mul/exec_b", vb, mk(0,0,0,0,0,3'b000,0,0,1,0,0,1));
    chk("mul/trap_c", vc, v_trap);
    step();
    chk("mul/wait3_a", va, v_busy);
    chk("mul/wb_b", vb, v_wb);
    chk("mul/done_c", vc, v_idle);
    step();
    chk("mul/wait4_a", va, v_busy);
    chk("mul/done_b", vb, v_idle);
    step();
    chk("mul/wait5_a", va, v_busy);
    step();
    chk("mul/wb_a", va, v_wb);
    step();
    chk("mul/done_a", va, v_idle);
    chk("mul/idle_b", vb, v_idle);
    chk("mul/idle_c", vc, v_idle);

    // BEQ retires in EXEC
    accept("beq", 7'b1100011, 7'b0000000);
    chk("beq/exec", va, mk(0,1,0,0,0,3'b011,0,0,0,1,0,1));
    step();
    chk("beq/done", va, v_idle);

    // Illegal opcode and illegal R-type funct7
    accept("ill_op", 7'b1111111, 7'b0000000);
    chk("ill_op/trap", va, v_trap);
    step();
    chk("ill_op/done", va, v_idle);
    accept("ill_f7", 7'b0110011, 7'b0000010);
    chk("ill_f7/trap", va, v_trap);
    step();

    // U / J type encodings
    accept("lui", 7'b0110111, 7'b0000000);
    chk("lui/exec", va, mk(0,0,0,0,0,3'b100,1,0,0,0,0,1));
    step();
    chk("lui/wb", va, v_wb);
    step();
    accept("auipc", 7'b0010111, 7'b0000000);
    chk("auipc/exec", va, mk(0,0,0,0,0,3'b100,1,0,0,0,0,1));
    step();
    step();
    accept("addi", 7'b0010011, 7'b0000000);
    chk("addi/exec", va, mk(0,0,0,0,0,3'b001,1,0,0,0,0,1));
    step();
    step();
    accept("jal", 7'b1101111, 7'b0000000);
    chk("jal/exec", va, mk(0,0,0,0,0,3'b101,1,0,0,0,0,1));
    step();
    step();
    accept("jalr", 7'b1100111, 7'b0000000);
    chk("jalr/exec", va, mk(0,0,0,0,0,3'b111,1,0,0,0,0,1));
    step();
    chk("jalr/wb", va, v_wb);
    step();

    // Reset asserted while a load waits in MEM
    accept("rst", 7'b0000011, 7'b0000000);
    step();
    chk("rst/mem", va, mk(0,0,1,0,0,3'b110,1,0,0,0,0,1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst/async", va, v_idle);
    mem_ready = 1'b1;
    step();
    chk("rst/held", va, v_idle);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst/after", va, v_idle);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
